// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the EX/MEM pipeline stage
package pipe_pkg;

  localparam int ANCHO_DEF    = 64;
  localparam int REG_BITS_DEF = 5;
  localparam logic [REG_BITS_DEF-1:0] XZR = 5'd31;

  typedef struct packed {
    logic [ANCHO_DEF-1:0]    alu;
    logic [ANCHO_DEF-1:0]    store_data;
    logic [ANCHO_DEF-1:0]    pc_branch;
    logic [REG_BITS_DEF-1:0] rd;
    logic                    z;
    logic                    cout;
    logic                    reg_write;
    logic                    mem_read;
    logic                    mem_write;
    logic                    branch_taken;
  } ex_mem_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

  // Writes to XZR are architecturally discarded, so they never count as a write.
  function automatic logic writes_reg(input logic rw, input logic [REG_BITS_DEF-1:0] rd);
    return rw && (rd != XZR);
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - two-entry valid/ready buffer with registered in_ready
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  buf_state_t   state, state_next;
  logic [W-1:0] head, skid;
  logic         load_h_in, load_h_skid, load_s;
  logic         push, pop;

  // Both handshake outputs depend only on registered state.
  assign in_ready  = (state != BUF_FULL);
  assign out_valid = (state != BUF_EMPTY);
  assign out_data  = head;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_next  = state;
    load_h_in   = 1'b0;
    load_h_skid = 1'b0;
    load_s      = 1'b0;
    if (clear) begin
      state_next = BUF_EMPTY;
    end else begin
      case (state)
        BUF_EMPTY: begin
          if (push) begin
            load_h_in  = 1'b1;
            state_next = BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (push && pop) begin
            load_h_in = 1'b1;
          end else if (push) begin
            load_s     = 1'b1;
            state_next = BUF_FULL;
          end else if (pop) begin
            state_next = BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (pop) begin
            load_h_skid = 1'b1;
            state_next  = BUF_ONE;
          end
        end
        default: state_next = BUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= BUF_EMPTY;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (load_h_in)        head <= in_data;
      else if (load_h_skid) head <= skid;
      if (load_s)           skid <= in_data;
    end
  end

endmodule

// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM stage register with branch resolve and forwarding tap
module ex_mem_reg
  import pipe_pkg::*;
#(
  parameter int ANCHO    = ANCHO_DEF,
  parameter int REG_BITS = REG_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ANCHO-1:0]    alu_out,
  input  logic                alu_z,
  input  logic                alu_cout,
  input  logic [ANCHO-1:0]    store_data,
  input  logic [ANCHO-1:0]    pc_branch,
  input  logic [REG_BITS-1:0] rd,
  input  logic                reg_write,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic                branch,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ANCHO-1:0]    out_alu,
  output logic [ANCHO-1:0]    out_store_data,
  output logic [ANCHO-1:0]    out_pc_branch,
  output logic [REG_BITS-1:0] out_rd,
  output logic                out_z,
  output logic                out_cout,
  output logic                out_reg_write,
  output logic                out_mem_read,
  output logic                out_mem_write,
  output logic                out_branch_taken,
  output logic                fwd_valid,
  output logic [REG_BITS-1:0] fwd_rd,
  output logic [ANCHO-1:0]    fwd_data
);

  ex_mem_t cap, head;

  always_comb begin
    cap              = '0;
    cap.alu          = alu_out;
    cap.store_data   = store_data;
    cap.pc_branch    = pc_branch;
    cap.rd           = rd;
    cap.z            = alu_z;
    cap.cout         = alu_cout;
    cap.reg_write    = writes_reg(reg_write, rd);
    cap.mem_read     = mem_read;
    cap.mem_write    = mem_write;
    cap.branch_taken = branch & alu_z;
  end

  // Flush discards the incoming instruction as well as everything held.
  pipe_skid_buf #(.W($bits(ex_mem_t))) u_buf (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .in_valid  (in_valid & ~flush),
    .in_ready  (in_ready),
    .in_data   (cap),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head)
  );

  assign out_alu          = head.alu;
  assign out_store_data   = head.store_data;
  assign out_pc_branch    = head.pc_branch;
  assign out_rd           = head.rd;
  assign out_z            = head.z;
  assign out_cout         = head.cout;
  assign out_reg_write    = head.reg_write;
  assign out_mem_read     = head.mem_read;
  assign out_mem_write    = head.mem_write;
  assign out_branch_taken = head.branch_taken;

  // A load's result is not available until MEM, so it cannot be bypassed from here.
  assign fwd_valid = out_valid & head.reg_write & ~head.mem_read;
  assign fwd_rd    = head.rd;
  assign fwd_data  = head.alu;

endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

EX/MEM pipeline stage register for the 64-bit pipelined datapath; it sits directly downstream of the ALU. It captures the ALU result, zero flag and carry-out, together with the control and store data that travel with the instruction. It resolves CBZ-style branches (branch & zero) at capture. It holds up to two instructions in an elastic valid/ready buffer, so memory-stage stalls do not combinationally back-propagate into EX. It also exports a forwarding tap for EX-hazard bypass.

## Interface
- ANCHO, 64, datapath width (ALU result, store data, branch target)
- REG_BITS, 5, destination register index width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- in_valid  in  1  EX presents a valid instruction
- in_ready  out  1  stage can accept this cycle
- alu_out  in  ANCHO  ALU result
- alu_z  in  1  ALU zero flag
- alu_cout  in  1  ALU adder carry-out
- store_data  in  ANCHO  register value for STUR
- pc_branch  in  ANCHO  computed branch target
- rd  in  REG_BITS  destination register
- reg_write, mem_read, mem_write, branch  in  1 each  control bits from ID/EX
- flush  in  1  kill all held and incoming instructions
- out_valid  out  1  head entry valid
- out_ready  in  1  MEM accepts head
- out_alu, out_store_data, out_pc_branch  out  ANCHO  head fields
- out_rd  out  REG_BITS; out_z, out_cout, out_reg_write, out_mem_read, out_mem_write, out_branch_taken  out  1 each
- fwd_valid  out  1  head can forward (out_valid & out_reg_write & ~out_mem_read)
- fwd_rd  out  REG_BITS; fwd_data  out  ANCHO  (= out_rd, out_alu)

## Operation
- Storage: two entries, head (H) and skid (S), plus 2-bit count (0..2).
- in_ready = (count != 2). It is a function of registered state only, with no path from out_ready.
- Push = in_valid & in_ready & ~flush. Pop = out_valid & out_ready.
- count 0, push: entry written to H.
- count 1:
  - push only: entry written to S.
  - pop only: count becomes 0.
  - push & pop: entry written to H, count stays 1.
- count 2:
  - pop: S moves to H, count becomes 1.
  - Push is impossible in this state.
- Capture transforms:
  - branch_taken = branch & alu_z.
  - reg_write forced to 0 when rd == XZR (31).
  - All other fields are stored verbatim. No width change, no arithmetic on alu_out.
- out_* always reflect H. When count == 0, out_valid = 0 and the data fields hold their last value.
- flush: count set to 0 next edge; any same-cycle push is discarded. flush has priority over push and pop.
- reset (synchronous): count 0, all registered fields 0, so all out_* and fwd_* read 0 and in_ready reads 1 after the edge.
- reset asserted mid-stall discards both entries. reset and flush together behave as reset.

## Timing
- Latency: 1 cycle from an accepted push into an empty stage to out_valid = 1.
- Throughput: 1 instruction/cycle while out_ready = 1 (steady state count = 1).
- in_ready deasserts the cycle after count reaches 2 and reasserts the cycle after the pop that leaves count = 1.
- Handshake rules:
  - Producer must hold in_valid and fields stable until in_ready.
  - out_valid and head fields stay stable until popped or flushed.
- fwd_* are combinational from H and valid in the same cycle as out_valid.

## Structure
- Shared package pipe_pkg holds:
  - typedef ex_mem_t: packed struct of all per-instruction fields.
  - localparam XZR = 5'd31.
  - localparam ANCHO_DEF = 64.
- Natural sub-module: pipe_skid_buf, a generic two-entry valid/ready buffer parameterised on payload width, carrying ex_mem_t. ex_mem_reg adds the capture transforms, flush gating and forwarding tap.

## Test plan
- Reset: assert reset 2 cycles with in_valid = 1 -> out_valid = 0, out_alu = 0, fwd_valid = 0, in_ready = 1; first push after release appears 1 cycle later.
- Streaming: 8 back-to-back pushes (alu_out = 1..8, rd = 1..8, reg_write = 1), out_ready = 1 -> outputs 1..8 on consecutive cycles, in_ready constantly 1, fwd_rd tracks rd.
- Backpressure: out_ready = 0, push alu_out = 0xA then 0xB -> in_ready = 0 after second push and a third push is held; raise out_ready -> 0xA, 0xB, third value pop in order, no loss or duplication.
- Branch/XZR:
  - branch = 1, alu_z = 1 -> out_branch_taken = 1.
  - branch = 1, alu_z = 0 -> 0.
  - rd = 31, reg_write = 1 -> out_reg_write = 0, fwd_valid = 0.
  - alu_cout = 1 passes to out_cout = 1.
- Load forwarding: mem_read = 1, reg_write = 1, rd = 4 -> out_valid = 1, fwd_valid = 0.
- Flush: count = 2 plus simultaneous push with flush -> next cycle out_valid = 0, in_ready = 1; subsequent push of 0x55 is the only value output.
